// File: rtl/porta_pkg.sv
// Shared constants for the portable joystick pad input conditioner.
package porta_pkg;

  localparam int PAD_W = 6;

  // Bit positions within a pad vector {P6,P5,P3,P2,P1,P0}
  localparam int PAD_P0 = 0;
  localparam int PAD_P1 = 1;
  localparam int PAD_P2 = 2;
  localparam int PAD_P3 = 3;
  localparam int PAD_P5 = 4;
  localparam int PAD_P6 = 5;

  localparam logic [PAD_W-1:0] PAD_RELEASED = 6'h3F;

  localparam int TICK_DIV_DEF       = 3580;
  localparam int DEBOUNCE_TICKS_DEF = 5;

endpackage

// File: rtl/porta_debounce_bit.sv
// One pad line: two-flop synchroniser, tick-counted mismatch filter and stable level.
module porta_debounce_bit
  import porta_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic out,
  output logic accept
);

  localparam int CW = $clog2(DEBOUNCE_TICKS) + 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any cycle of agreement discards the partial count, tick or not.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
        stable_d = sync2_q;
        cnt_d    = '0;
        accept   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign out = stable_q;

endmodule

// File: rtl/porta_ctrl_debounce.sv
// Debounces both joystick pads against a shared prescaled sample tick and flags per-player updates.
module porta_ctrl_debounce
  import porta_pkg::*;
#(
  parameter int TICK_DIV       = TICK_DIV_DEF,
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PAD_W-1:0] C1_RAW,
  input  logic [PAD_W-1:0] C2_RAW,
  output logic [PAD_W-1:0] C1P,
  output logic [PAD_W-1:0] C2P,
  output logic             C1_CHG,
  output logic             C2_CHG,
  output logic             TICK
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0]      presc_q, presc_d;
  logic               c1_chg_q, c1_chg_d;
  logic               c2_chg_q, c2_chg_d;
  logic               tick;
  logic [2*PAD_W-1:0] raw_all;
  logic [2*PAD_W-1:0] out_all;
  logic [2*PAD_W-1:0] acc_all;

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign raw_all = {C2_RAW, C1_RAW};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      c1_chg_q <= 1'b0;
      c2_chg_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      c1_chg_q <= c1_chg_d;
      c2_chg_q <= c2_chg_d;
    end
  end

  always_comb begin
    presc_d  = tick ? '0 : presc_q + PW'(1);
    c1_chg_d = |acc_all[PAD_W-1:0];
    c2_chg_d = |acc_all[2*PAD_W-1:PAD_W];
  end

  // Lower PAD_W instances serve player 1, upper PAD_W serve player 2.
  generate
    for (genvar gi = 0; gi < 2 * PAD_W; gi++) begin : g_bit
      porta_debounce_bit #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
      ) u_bit (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .raw   (raw_all[gi]),
        .out   (out_all[gi]),
        .accept(acc_all[gi])
      );
    end
  endgenerate

  assign C1P    = out_all[PAD_W-1:0];
  assign C2P    = out_all[2*PAD_W-1:PAD_W];
  assign C1_CHG = c1_chg_q;
  assign C2_CHG = c2_chg_q;
  assign TICK   = tick;

endmodule

// File: tb/tb_porta_ctrl_debounce.sv
// Scoreboard bench: a cycle-level reference model predicts pad updates, a monitor checks them.
module tb_porta_ctrl_debounce;
  import porta_pkg::*;

  localparam int TD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] c1_raw, c2_raw;
  logic [5:0] c1p, c2p;
  logic       c1_chg, c2_chg, tick_o;

  porta_ctrl_debounce #(.TICK_DIV(TD), .DEBOUNCE_TICKS(DB)) dut (
    .clk(clk), .rst(rst), .C1_RAW(c1_raw), .C2_RAW(c2_raw),
    .C1P(c1p), .C2P(c2p), .C1_CHG(c1_chg), .C2_CHG(c2_chg), .TICK(tick_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int chg1_cnt = 0;
  int chg2_cnt = 0;

  // Reference model state: raw history, accepted levels, ticks seen in current disagreement run
  logic [11:0] m_hist0, m_hist1, m_stab;
  int          m_run [12];
  int          m_cyc;
  logic        m_tick;
  logic [5:0]  q1 [$];
  logic [5:0]  q2 [$];

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist0 = '1;
    m_hist1 = '1;
    m_stab  = '1;
    for (int b = 0; b < 12; b++) m_run[b] = 0;
    m_cyc  = 0;
    m_tick = 1'b0;
    q1.delete();
    q2.delete();
  endtask

  task automatic model_step();
    logic [11:0] seen;
    logic [11:0] acc;
    seen = m_hist1;
    acc  = '0;
    for (int b = 0; b < 12; b++) begin
      if (seen[b] == m_stab[b]) m_run[b] = 0;
      else if (m_tick) begin
        m_run[b] = m_run[b] + 1;
        if (m_run[b] == DB) begin
          m_stab[b] = seen[b];
          m_run[b]  = 0;
          acc[b]    = 1'b1;
        end
      end
    end
    m_hist1 = m_hist0;
    m_hist0 = {c2_raw, c1_raw};
    m_cyc   = m_cyc + 1;
    m_tick  = ((m_cyc % TD) == TD - 1);
    if (|acc[5:0])  q1.push_back(m_stab[5:0]);
    if (|acc[11:6]) q2.push_back(m_stab[11:6]);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Monitor: every update strobe must match a queued prediction
  initial begin
    logic [5:0] e;
    bit         pend;
    forever begin
      @(negedge clk);
      pend = (q1.size() > 0);
      chk(c1_chg === pend, "c1_chg", int'(c1_chg), int'(pend));
      e = pend ? q1.pop_front() : m_stab[5:0];
      chk(c1p === e, "c1p", int'(c1p), int'(e));
      pend = (q2.size() > 0);
      chk(c2_chg === pend, "c2_chg", int'(c2_chg), int'(pend));
      e = pend ? q2.pop_front() : m_stab[11:6];
      chk(c2p === e, "c2p", int'(c2p), int'(e));
      chk(tick_o === m_tick, "tick", int'(tick_o), int'(m_tick));
      if (c1_chg) chg1_cnt++;
      if (c2_chg) chg2_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic measure(input int pl, input logic [5:0] mask, input logic [5:0] val,
                         input int lo, input int hi, input string nm);
    int n;
    bit hit;
    logic [5:0] cur;
    n   = 0;
    hit = 0;
    while (!hit && n < 40) begin
      cyc(1);
      n++;
      cur = (pl == 1) ? c1p : c2p;
      if ((cur & mask) == val) hit = 1;
    end
    chk(hit && n >= lo && n <= hi, nm, hit ? n : -1, lo);
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (!tick_o && n < 10) begin
      cyc(1);
      n++;
    end
    chk(tick_o === 1'b1, "wait_tick", n, TD);
  endtask

  initial begin
    int b1, b2, n;
    bit fell, hit;
    logic [5:0] all_m;
    logic [5:0] exp_v;
    all_m = 6'(1) << PAD_P0 | 6'(1) << PAD_P1 | 6'(1) << PAD_P2 |
            6'(1) << PAD_P3 | 6'(1) << PAD_P5 | 6'(1) << PAD_P6;
    c1_raw = '1;
    c2_raw = '1;
    #1 rst = 1'b1;

    // Reset held with player 1 pressed
    c1_raw = '0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk(c1p == PAD_RELEASED, "rst_hold_c1p", int'(c1p), int'(PAD_RELEASED));
    end
    chk(c1_chg == 1'b0 && tick_o == 1'b0, "rst_hold_strobes", int'({c1_chg, tick_o}), 0);
    b1  = chg1_cnt;
    rst = 1'b0;
    measure(1, all_m, 6'h00, 2 + (DB-1)*TD + 1, 2 + DB*TD, "rst_release_latency");
    cyc(20);
    chk(chg1_cnt - b1 == 1, "rst_release_chg_once", chg1_cnt - b1, 1);
    c1_raw = '1;
    cyc(30);

    // Clean press on player 2 P3 at a random phase
    cyc($urandom_range(0, 3));
    b1 = chg1_cnt;
    b2 = chg2_cnt;
    c2_raw[PAD_P3] = 1'b0;
    measure(2, 6'(1) << PAD_P3, 6'h00, 11, 14, "clean_press_latency");
    cyc(10);
    chk(chg2_cnt - b2 == 1, "clean_press_c2_chg", chg2_cnt - b2, 1);
    chk(chg1_cnt - b1 == 0, "clean_press_c1_quiet", chg1_cnt - b1, 0);
    exp_v = PAD_RELEASED & ~(6'(1) << PAD_P3);
    chk(c2p == exp_v, "clean_press_others", int'(c2p), int'(exp_v));
    c2_raw = '1;
    cyc(30);

    // Short glitches at each prescaler phase are rejected
    for (int ph = 0; ph < TD; ph++) begin
      wait_tick();
      cyc(ph);
      b1 = chg1_cnt;
      c1_raw[PAD_P0] = 1'b0;
      cyc((DB-1)*TD);
      c1_raw[PAD_P0] = 1'b1;
      cyc(20);
      chk(c1p[PAD_P0] == 1'b1, "glitch8_level", int'(c1p[PAD_P0]), 1);
      chk(chg1_cnt - b1 == 0, "glitch8_chg", chg1_cnt - b1, 0);
    end

    // Slightly longer pulses always get through
    for (int ph = 0; ph < TD; ph++) begin
      wait_tick();
      cyc(ph);
      fell = 0;
      c1_raw[PAD_P0] = 1'b0;
      for (int i = 0; i < 13; i++) begin
        cyc(1);
        if (c1p[PAD_P0] == 1'b0) fell = 1;
      end
      c1_raw[PAD_P0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        cyc(1);
        if (c1p[PAD_P0] == 1'b0) fell = 1;
      end
      chk(fell, "glitch13_falls", int'(fell), 1);
      cyc(30);
    end

    // Bouncing line, then settling low
    b1 = chg1_cnt;
    for (int i = 0; i < 40; i++) begin
      c1_raw[PAD_P6] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      cyc(1);
    end
    chk(chg1_cnt - b1 == 0 && c1p == PAD_RELEASED, "bounce_quiet", int'(c1p), int'(PAD_RELEASED));
    c1_raw[PAD_P6] = 1'b0;
    measure(1, 6'(1) << PAD_P6, 6'h00, 11, 14, "bounce_settle_latency");
    cyc(10);
    chk(chg1_cnt - b1 == 1, "bounce_single_chg", chg1_cnt - b1, 1);
    c1_raw = '1;
    cyc(30);

    // All twelve lines pressed on one cycle
    b1 = chg1_cnt;
    b2 = chg2_cnt;
    c1_raw = ~all_m;
    c2_raw = ~all_m;
    n   = 0;
    hit = 0;
    while (!hit && n < 20) begin
      cyc(1);
      n++;
      if (c1p != PAD_RELEASED || c2p != PAD_RELEASED) hit = 1;
    end
    chk(hit && c1p == 6'h00 && c2p == 6'h00, "simul_same_cycle", int'({c2p, c1p}), 0);
    chk(c1_chg && c2_chg, "simul_chg_together", int'({c2_chg, c1_chg}), 3);
    cyc(10);
    chk(chg1_cnt - b1 == 1 && chg2_cnt - b2 == 1, "simul_chg_once",
        (chg1_cnt - b1) * 10 + (chg2_cnt - b2), 11);
    c1_raw = '1;
    c2_raw = '1;
    cyc(30);

    // Reset after two ticks of a pending press
    wait_tick();
    c1_raw[PAD_P1] = 1'b0;
    cyc(9);
    chk(c1p == PAD_RELEASED, "midrst_not_yet", int'(c1p), int'(PAD_RELEASED));
    rst = 1'b1;
    #1;
    chk(c1p == PAD_RELEASED && c2p == PAD_RELEASED && !c1_chg, "midrst_immediate",
        int'({c2p, c1p}), 12'hFFF);
    cyc(1);
    rst = 1'b0;
    measure(1, 6'(1) << PAD_P1, 6'h00, 11, 14, "midrst_repress_latency");
    c1_raw = '1;
    cyc(30);

    // Randomised traffic against the model
    for (int i = 0; i < 80; i++) begin
      c1_raw = 6'($urandom);
      c2_raw = 6'($urandom);
      cyc($urandom_range(1, 24));
    end
    cyc(30);
    chk(q1.size() == 0 && q2.size() == 0, "queues_drained", q1.size() + q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
